clk_phase_monitor: RTL and testbench

- Receiving end of the divided-clock interface. Consumes dmem_clk, reg_clk and pro_clk from the clock divider, sampled on the fast master clock clk.
- Checks the phase sequence, declares lock, and emits single-cycle edge strobes in the clk domain so logic can run on clock enables instead of derived clocks.
- Counts phase errors and raises a sticky fault when the error limit is reached.

---
 rtl/clk_phase_monitor.sv | 185 ++++++++++++++++++
 tb/tb_clk_phase_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_phase_monitor.sv
// ---------------------------------------------------------------------------
// clk_phase_monitor
//
// This block sits at the receiving end of the divided-clock interface. It
// samples dmem_clk, reg_clk and pro_clk on the fast master clock clk and
// checks that they follow the expected phase sequence. Once the sequence has
// been stable for long enough, it declares lock. While locked, it emits
// single-cycle edge strobes in the clk domain. Downstream logic can then run
// on clock enables instead of on derived clocks.
//
// Phase errors seen while locked are counted. A sticky fault is raised when
// the count reaches FAULT_LIMIT.
//
// Valid/ready: there is no handshake here. Every clk edge takes one sample
// unconditionally. The outputs are registered and follow the inputs with a
// latency of two edges: a sample pair taken at edges k-1 and k is resolved
// at edge k+1.
//
// Ports:
//   clk        in   master clock (the same clock that drives the divider)
//   rst        in   asynchronous, active-high reset
//   dmem_clk   in   divided clock, period 2 clk
//   reg_clk    in   divided clock, period 4 clk, must equal pro_clk
//   pro_clk    in   divided clock, period 4 clk
//   clr_err    in   single-cycle pulse: clears err_cnt and leaves FAULT
//   locked     out  high while in LOCKED
//   fault      out  sticky fault flag
//   phase      out  {pro,dmem} of the checked sample while locked, else 0
//   pro_rise   out  strobe: pro_clk rose
//   pro_fall   out  strobe: pro_clk fell
//   dmem_rise  out  strobe: dmem_clk rose
//   err_cnt    out  saturating phase-error count
// ---------------------------------------------------------------------------
module clk_phase_monitor #(
    parameter int LOCK_CNT    = 8,
    parameter int ERR_W       = 8,
    parameter int FAULT_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmem_clk,
    input  logic             reg_clk,
    input  logic             pro_clk,
    input  logic             clr_err,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       phase,
    output logic             pro_rise,
    output logic             pro_fall,
    output logic             dmem_rise,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    localparam logic [7:0]       LOCK_V  = LOCK_CNT[7:0];
    localparam logic [ERR_W-1:0] FLIM_V  = FAULT_LIMIT[ERR_W-1:0];
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       smp;
    logic [1:0]       prv;
    logic             rsmp;
    logic             smp_v;
    logic             prv_v;
    logic [7:0]       run;

    logic [1:0]       smp_exp;
    logic             good;
    logic [7:0]       run_inc;
    logic [ERR_W-1:0] err_inc;
    logic             err_trip;

    // The legal sequence counts 00,01,10,11 in {pro,dmem}. reg_clk must
    // track pro_clk exactly.
    always_comb begin
        smp_exp  = prv + 2'd1;
        good     = prv_v && (smp == smp_exp) && (rsmp == smp[1]);
        run_inc  = run + 8'd1;
        err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
        err_trip = (err_inc >= FLIM_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SEARCH;
            smp       <= 2'b00;
            prv       <= 2'b00;
            rsmp      <= 1'b0;
            smp_v     <= 1'b0;
            prv_v     <= 1'b0;
            run       <= 8'd0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            phase     <= 2'b00;
            pro_rise  <= 1'b0;
            pro_fall  <= 1'b0;
            dmem_rise <= 1'b0;
            err_cnt   <= '0;
        end else begin
            smp   <= {pro_clk, dmem_clk};
            rsmp  <= reg_clk;
            smp_v <= 1'b1;
            prv   <= smp;
            prv_v <= smp_v;

            pro_rise  <= 1'b0;
            pro_fall  <= 1'b0;
            dmem_rise <= 1'b0;

            // In SEARCH, TRACK and LOCKED a clear affects only the counter.
            // In LOCKED, the error branch below gives the clear priority
            // over the increment.
            if (clr_err) begin
                err_cnt <= '0;
            end

            case (state)
                S_SEARCH: begin
                    // A mismatch here is not an error. An all-zero stream
                    // while the divider is still held in reset must not
                    // count.
                    if (good) begin
                        run <= 8'd1;
                        if (LOCK_V == 8'd1) begin
                            state  <= S_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    if (prv_v) begin
                        if (good) begin
                            run <= run_inc;
                            if (run_inc == LOCK_V) begin
                                state  <= S_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            state <= S_SEARCH;
                            run   <= 8'd0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (good) begin
                        phase     <= smp;
                        pro_rise  <= (smp == 2'b10);
                        pro_fall  <= (smp == 2'b00);
                        dmem_rise <= smp[0];
                    end else begin
                        locked <= 1'b0;
                        run    <= 8'd0;
                        phase  <= 2'b00;
                        if (clr_err) begin
                            state <= S_SEARCH;
                        end else begin
                            err_cnt <= err_inc;
                            if (err_trip) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state <= S_SEARCH;
                            end
                        end
                    end
                end
                default: begin
                    // S_FAULT: the input sequence is ignored. Only a clear
                    // leaves this state.
                    if (clr_err) begin
                        state <= S_SEARCH;
                        fault <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_phase_monitor.sv
module tb_clk_phase_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       dmem_clk;
    logic       reg_clk;
    logic       pro_clk;
    logic       clr_err;
    logic       locked;
    logic       fault;
    logic [1:0] phase;
    logic       pro_rise;
    logic       pro_fall;
    logic       dmem_rise;
    logic [7:0] err_cnt;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] cur;

    clk_phase_monitor #(
        .LOCK_CNT    (8),
        .ERR_W       (8),
        .FAULT_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_clk  (dmem_clk),
        .reg_clk   (reg_clk),
        .pro_clk   (pro_clk),
        .clr_err   (clr_err),
        .locked    (locked),
        .fault     (fault),
        .phase     (phase),
        .pro_rise  (pro_rise),
        .pro_fall  (pro_fall),
        .dmem_rise (dmem_rise),
        .err_cnt   (err_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge, and
    // outputs are checked at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic p, input logic d, input logic r);
        pro_clk  = p;
        dmem_clk = d;
        reg_clk  = r;
        tick();
    endtask

    task automatic step_good();
        cur = cur + 2'd1;
        drive_raw(cur[1], cur[0], cur[1]);
    endtask

    task automatic relock_check(input string tag);
        for (int i = 0; i < 7; i++) begin
            step_good();
            check({tag, "_pre"}, locked, 0);
        end
        step_good();
        check(tag, locked, 1);
    endtask

    task automatic after_error(input string tag, input int exp_err, input logic exp_fault);
        step_good();
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_fault"}, fault, exp_fault);
        check({tag, "_strobes"}, {pro_rise, pro_fall, dmem_rise}, 0);
        check({tag, "_phase"}, phase, 0);
    endtask

    task automatic inject_repeat(input string tag, input int exp_err, input logic exp_fault);
        drive_raw(cur[1], cur[0], cur[1]);
        check({tag, "_still_locked"}, locked, 1);
        after_error(tag, exp_err, exp_fault);
    endtask

    initial begin
        int n_pr;
        int n_pf;
        int n_dr;
        logic [1:0] exp_ph;

        rst      = 1'b1;
        pro_clk  = 1'b0;
        dmem_clk = 1'b0;
        reg_clk  = 1'b0;
        clr_err  = 1'b0;
        cur      = 2'd3;
        tick();
        tick();
        check("rst_locked", locked, 0);
        check("rst_fault", fault, 0);
        check("rst_err", err_cnt, 0);
        check("rst_phase", phase, 0);
        check("rst_strobes", {pro_rise, pro_fall, dmem_rise}, 0);
        rst = 1'b0;

        // Initial lock: locked stays low through edge 9 and rises at edge 10.
        step_good();
        check("lock_e1", locked, 0);
        step_good();
        check("lock_e2", locked, 0);
        relock_check("lock_e10");
        check("lock_err", err_cnt, 0);
        check("lock_strobes", {pro_rise, pro_fall, dmem_rise}, 0);

        // 16 locked clocks. Phase shows the sample taken one edge earlier.
        n_pr = 0;
        n_pf = 0;
        n_dr = 0;
        for (int i = 0; i < 16; i++) begin
            step_good();
            exp_ph = cur - 2'd1;
            check("trk_phase", phase, exp_ph);
            check("trk_pro_rise", pro_rise, exp_ph == 2'b10);
            check("trk_pro_fall", pro_fall, exp_ph == 2'b00);
            check("trk_dmem_rise", dmem_rise, exp_ph[0]);
            n_pr += pro_rise;
            n_pf += pro_fall;
            n_dr += dmem_rise;
        end
        check("cnt_pro_rise", n_pr, 4);
        check("cnt_pro_fall", n_pf, 4);
        check("cnt_dmem_rise", n_dr, 8);

        // dmem held for one extra clk
        inject_repeat("err1", 1, 1'b0);
        relock_check("relock1");

        // reg_clk inverted for one sample
        cur = cur + 2'd1;
        drive_raw(cur[1], cur[0], ~cur[1]);
        check("err2_still_locked", locked, 1);
        after_error("err2", 2, 1'b0);
        relock_check("relock2");

        inject_repeat("err3", 3, 1'b0);
        relock_check("relock3");

        // The fourth error reaches the limit. Fault is sticky on good input.
        inject_repeat("err4", 4, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step_good();
            check("flt_fault", fault, 1);
            check("flt_locked", locked, 0);
            check("flt_strobes", {pro_rise, pro_fall, dmem_rise, phase}, 0);
        end
        clr_err = 1'b1;
        step_good();
        clr_err = 1'b0;
        check("clr_fault", fault, 0);
        check("clr_err", err_cnt, 0);
        relock_check("relock_clr");

        // Reset asserted mid-period while locked
        step_good();
        #3;
        rst = 1'b1;
        #1;
        check("mrst_locked", locked, 0);
        check("mrst_outs", {fault, phase, pro_rise, pro_fall, dmem_rise, err_cnt}, 0);
        tick();
        rst = 1'b0;
        cur = 2'd0;
        for (int i = 0; i < 10; i++) begin
            drive_raw(1'b0, 1'b0, 1'b0);
            check("hold_locked", locked, 0);
            check("hold_err", err_cnt, 0);
        end
        step_good();
        check("resume_e1", locked, 0);
        relock_check("relock_rst");
        check("final_err", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
